// File: rtl/pwm_desorption_core.sv
// Desorption heater PWM core: pad-level register writes, start/abort control,
// and one complementary dead-time-protected PWM pair with status and pulse count.
module pwm_desorption_core #(
    parameter int CNT_W       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [16:0] ui_PAD2CORE,
    output logic [16:0] uo_CORE2PAD
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int               CMP_W      = CNT_W + 9;
    localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(1000);
    localparam logic [7:0]       DEAD_RST   = 8'd4;
    localparam logic [8:0]       LEN_MAX    = '1;

    logic [16:0]      sync_q [SYNC_STAGES];
    logic [16:0]      sync_d [SYNC_STAGES];
    logic             stb_prev_q, stb_prev_d, start_prev_q, start_prev_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] period_sh_q, period_sh_d, duty_sh_q, duty_sh_d;
    logic [CNT_W-1:0] pulses_sh_q, pulses_sh_d;
    logic [7:0]       dead_sh_q, dead_sh_d;
    logic [CNT_W-1:0] period_q, period_d, duty_q, duty_d, pulses_q, pulses_d;
    logic [7:0]       dead_q, dead_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, count_q, count_d;
    logic [8:0]       hi_len_q, hi_len_d, lo_len_q, lo_len_d;
    logic             pwm_hi_q, pwm_hi_d, pwm_lo_q, pwm_lo_d;
    logic             done_q, done_d, err_q, err_d;

    logic [16:0]      pad_s;
    logic             stb_rise, start_rise, abort, cfg_ok, wrap, raw_d;
    logic [11:0]      count_field;

    always_comb begin
        sync_d[0] = ui_PAD2CORE;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        pad_s      = sync_q[SYNC_STAGES-1];
        stb_rise   = pad_s[14] & ~stb_prev_q;
        start_rise = pad_s[15] & ~start_prev_q;
        abort      = pad_s[16];
        cfg_ok     = (period_sh_q >= CNT_W'(2)) && (duty_sh_q <= period_sh_q) &&
                     (CMP_W'(dead_sh_q) < CMP_W'(period_sh_q));
        wrap       = (state_q == RUN) && (cnt_q == period_q - CNT_W'(1));
    end

    always_comb begin
        stb_prev_d   = pad_s[14];
        start_prev_d = pad_s[15];
        state_d      = state_q;
        period_sh_d  = period_sh_q;
        duty_sh_d    = duty_sh_q;
        pulses_sh_d  = pulses_sh_q;
        dead_sh_d    = dead_sh_q;
        period_d     = period_q;
        duty_d       = duty_q;
        pulses_d     = pulses_q;
        dead_d       = dead_q;
        cnt_d        = cnt_q;
        count_d      = count_q;
        done_d       = done_q;
        err_d        = err_q;

        if (stb_rise) begin
            err_d = 1'b0;
            case (pad_s[13:12])
                2'd0:    period_sh_d = pad_s[CNT_W-1:0];
                2'd1:    duty_sh_d   = pad_s[CNT_W-1:0];
                2'd2:    pulses_sh_d = pad_s[CNT_W-1:0];
                default: dead_sh_d   = pad_s[7:0];
            endcase
        end

        case (state_q)
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    // PERIOD/DUTY follow the shadows only at a period boundary
                    cnt_d    = '0;
                    period_d = period_sh_q;
                    duty_d   = duty_sh_q;
                    count_d  = count_q + CNT_W'(1);
                    if ((pulses_q != '0) && (count_d == pulses_q)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start_rise) begin
                    if (cfg_ok) begin
                        state_d  = RUN;
                        period_d = period_sh_q;
                        duty_d   = duty_sh_q;
                        pulses_d = pulses_sh_q;
                        dead_d   = dead_sh_q;
                        cnt_d    = '0;
                        count_d  = '0;
                        done_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase

        // Run lengths of raw high/low; a side turns on once its run exceeds DEAD
        raw_d    = (cnt_d < duty_d);
        hi_len_d = '0;
        lo_len_d = '0;
        if (state_d == RUN) begin
            if (raw_d) begin
                hi_len_d = (hi_len_q == LEN_MAX) ? hi_len_q : hi_len_q + 9'd1;
            end else begin
                lo_len_d = (lo_len_q == LEN_MAX) ? lo_len_q : lo_len_q + 9'd1;
            end
        end
        pwm_hi_d = (hi_len_d > {1'b0, dead_d});
        pwm_lo_d = (lo_len_d > {1'b0, dead_d});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            stb_prev_q   <= 1'b0;
            start_prev_q <= 1'b0;
            state_q      <= IDLE;
            period_sh_q  <= PERIOD_RST;
            duty_sh_q    <= '0;
            pulses_sh_q  <= '0;
            dead_sh_q    <= DEAD_RST;
            period_q     <= PERIOD_RST;
            duty_q       <= '0;
            pulses_q     <= '0;
            dead_q       <= DEAD_RST;
            cnt_q        <= '0;
            count_q      <= '0;
            hi_len_q     <= '0;
            lo_len_q     <= '0;
            pwm_hi_q     <= 1'b0;
            pwm_lo_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            stb_prev_q   <= stb_prev_d;
            start_prev_q <= start_prev_d;
            state_q      <= state_d;
            period_sh_q  <= period_sh_d;
            duty_sh_q    <= duty_sh_d;
            pulses_sh_q  <= pulses_sh_d;
            dead_sh_q    <= dead_sh_d;
            period_q     <= period_d;
            duty_q       <= duty_d;
            pulses_q     <= pulses_d;
            dead_q       <= dead_d;
            cnt_q        <= cnt_d;
            count_q      <= count_d;
            hi_len_q     <= hi_len_d;
            lo_len_q     <= lo_len_d;
            pwm_hi_q     <= pwm_hi_d;
            pwm_lo_q     <= pwm_lo_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        count_field              = '0;
        count_field[CNT_W-1:0]   = count_q;
    end

    assign uo_CORE2PAD = {count_field, err_q, done_q, (state_q == RUN), pwm_lo_q, pwm_hi_q};

endmodule
